seg_display_arbiter: RTL
========================

// Module: seg_display_arbiter
// PURPOSE
//  Owns the multi-digit 7-segment display: two requesters (A = pattern/animation
//  engine, B = host/status logic) share it through valid/ready digit-write ports.
//  Writes land in a back frame buffer; a commit copies it to the front buffer
//  tear-free at the next scan-frame boundary. A prescaled scanner drives seg/an.
// PARAMETERS
//  NUM_DIGITS  7   digits on the display; an width; buffer depth (>=2)
//  SCAN_DIV    4   clk cycles per digit dwell (>=2)
//  IDX_W       3   digit index width, $clog2(NUM_DIGITS)
// PORTS
//  clk        in   1           clock
//  reset      in   1           asynchronous, active-high
//  en         in   1           1 = scan display; 0 = blank
//  a_valid    in   1           requester A write request
//  a_ready    out  1           A write accepted this cycle
//  a_idx      in   IDX_W       A target digit (0 = leftmost = an[NUM_DIGITS-1])
//  a_seg      in   7           A pattern, abcdefg, active-high, seg[6] = a
//  b_valid/b_ready/b_idx/b_seg  same as A, requester B
//  commit     in   1           pulse: publish back buffer at next frame boundary
//  commit_pend out 1           commit requested, not yet applied
//  frame_start out 1           1-cycle pulse when digit 0 is driven
//  wr_err     out  1           1-cycle pulse: accepted write had idx >= NUM_DIGITS
//  seg        out  7           segment drive of the current digit, active-high
//  an         out  NUM_DIGITS  digit enable, active-low, one-hot-low
// BEHAVIOUR
//  Reset: seg=0, an=all 1s, front/back buffers 0, idx=0, prescaler=0,
//   commit_pend=0, frame_start=0, wr_err=0, last_grant=B (A wins first tie).
//  Arbitration (combinational ready): only one valid -> that port ready;
//   both valid -> port not granted last; last_grant updates only on transfer.
//   Ready never asserts without valid. Transfer = valid && ready; back[idx] <=
//   seg on the next edge. idx >= NUM_DIGITS: accepted, discarded, wr_err pulses.
//  Prescaler: counts 0..SCAN_DIV-1 while en=1; tick when count == SCAN_DIV-1.
//   On tick, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1 (wrap).
//  Outputs are registered, updated on the same edge as idx, from the new idx:
//   seg <= front[new idx]; an <= all 1s except bit NUM_DIGITS-1-new idx = 0.
//   frame_start pulses with the edge that selects digit 0.
//  en rising: first cycle with en=1 loads digit 0 (seg/an valid next cycle,
//   frame_start pulses); a dwell then lasts SCAN_DIV cycles.
//  en=0: seg=0, an=all 1s, idx and prescaler cleared to 0; writes still accepted.
//  Commit: commit sets commit_pend. Swap (front <= back, copy; back retained)
//   occurs on the wrap tick (idx NUM_DIGITS-1 -> 0), so the new frame starts
//   at digit 0; with en=0, swap occurs on the next edge. commit_pend clears
//   on swap. Commit while pending merges. Commit in the swap cycle is kept
//   pending for the next frame.
//  Same-cycle write and swap: front gets the pre-write back value; the write
//   lands in back only.
//  Reset mid-frame/mid-write: everything returns to reset values; a pending
//   commit and an in-flight write are lost.
// STRUCTURE
//  seg_pkg: SEG_W=7, typedef logic [6:0] seg_t, SEG_BLANK='0,
//   function an_onehot_low(idx) returning NUM_DIGITS-bit active-low enable.
//  Sub-module seg_wr_arbiter: 2-port round-robin (valid in, ready out, grant
//   index, last_grant register). Top holds buffers, prescaler, scan, commit.
// TESTING (NUM_DIGITS=7, SCAN_DIV=4)
//  1 Reset then en=1, no writes -> seg=0 throughout; an steps 0111111,1011111,
//    ...,1111110 every 4 cycles then wraps; frame_start every 28 cycles.
//  2 A writes idx0=7'h1C; B writes idx3=7'h62; commit -> front unchanged
//    until wrap; first frame after wrap shows 1C with an=0111111 and 62 with
//    an=1110111; commit_pend high until the wrap edge.
//  3 a_valid and b_valid held high 6 cycles after reset -> grants A,B,A,B,A,B;
//    drop b_valid -> A granted every cycle.
//  4 A writes idx=7 -> a_ready=1, wr_err pulses 1 cycle, buffers unchanged.
//  5 en=0 mid-frame with commit pending -> next cycle an=1111111, seg=0,
//    swap done, commit_pend=0; en=1 -> restart at digit 0, frame_start pulse.
//  6 Write to back idx2 in the wrap-tick cycle of a pending commit -> front[2]
//    shows old back value; front[2] updates only after a second commit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display block.
package seg_pkg;

    localparam int SEG_W      = 7;
    localparam int MAX_DIGITS = 32;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = '0;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    // Active-low one-hot digit enable; digit 0 is the leftmost, i.e. the MSB.
    function automatic logic [MAX_DIGITS-1:0] an_onehot_low(input int unsigned idx,
                                                            input int unsigned num_digits);
        logic [MAX_DIGITS-1:0] one;
        one = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
        return ~(one << (num_digits - 1 - idx));
    endfunction

endpackage

// File: rtl/seg_wr_arbiter.sv
// Two-port round-robin arbiter for digit writes into the back frame buffer.
module seg_wr_arbiter
    import seg_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   a_valid,
    input  logic   b_valid,
    output logic   a_ready,
    output logic   b_ready,
    output grant_e grant,
    output logic   xfer,
    output grant_e last_grant
);

    // Handshake: ready is combinational, never asserts without its valid, and a
    // transfer happens on the edge where valid && ready; on contention the
    // port not granted last wins, and the history only moves on a transfer.
    grant_e last_grant_q, last_grant_d;

    always_comb begin
        a_ready      = a_valid && (!b_valid || last_grant_q == GNT_B);
        b_ready      = b_valid && (!a_valid || last_grant_q == GNT_A);
        grant        = b_ready ? GNT_B : GNT_A;
        xfer         = a_ready || b_ready;
        last_grant_d = xfer ? grant : last_grant_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GNT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/seg_display_arbiter.sv
// Shared 7-segment display: arbitrated writes into a back buffer, tear-free
// commit to the front buffer at frame wrap, and a prescaled digit scanner.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 7,
    parameter int SCAN_DIV   = 4,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [IDX_W-1:0]      a_idx,
    input  logic [SEG_W-1:0]      a_seg,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [IDX_W-1:0]      b_idx,
    input  logic [SEG_W-1:0]      b_seg,
    input  logic                  commit,
    output logic                  commit_pend,
    output logic                  frame_start,
    output logic                  wr_err,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    grant_e grant;
    grant_e last_grant_unused;
    logic   xfer;

    seg_wr_arbiter u_arb (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .a_ready    (a_ready),
        .b_ready    (b_ready),
        .grant      (grant),
        .xfer       (xfer),
        .last_grant (last_grant_unused)
    );

    seg_t [NUM_DIGITS-1:0] front_q, front_d;
    seg_t [NUM_DIGITS-1:0] back_q, back_d;
    seg_t [NUM_DIGITS-1:0] src;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  active_q, active_d;
    logic                  commit_pend_q, commit_pend_d;
    logic                  frame_start_q, frame_start_d;
    logic                  wr_err_q, wr_err_d;
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [MAX_DIGITS-1:0] an_full;
    logic                  an_unused;

    logic [IDX_W-1:0] w_idx;
    seg_t             w_seg;
    logic             in_range;
    logic             tick, wrap, swap, load;

    assign w_idx    = (grant == GNT_B) ? b_idx : a_idx;
    assign w_seg    = (grant == GNT_B) ? b_seg : a_seg;
    assign in_range = ({1'b0, w_idx} < (IDX_W+1)'(NUM_DIGITS));

    assign tick = active_q && (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    // While blanked there is no frame to tear, so a pending commit lands at once.
    assign swap = commit_pend_q && (en ? wrap : 1'b1);
    // A digit loaded on the swap edge must already show the new frame.
    assign src  = swap ? back_q : front_q;

    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        active_d      = active_q;
        seg_d         = seg_q;
        an_d          = an_q;
        frame_start_d = 1'b0;
        load          = 1'b0;
        an_full       = '1;

        if (!en) begin
            cnt_d    = '0;
            idx_d    = '0;
            active_d = 1'b0;
            seg_d    = SEG_BLANK;
            an_d     = '1;
        end else if (!active_q) begin
            active_d      = 1'b1;
            cnt_d         = '0;
            idx_d         = '0;
            load          = 1'b1;
            frame_start_d = 1'b1;
        end else if (tick) begin
            cnt_d         = '0;
            idx_d         = wrap ? '0 : idx_q + 1'b1;
            load          = 1'b1;
            frame_start_d = wrap;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (load) begin
            an_full = an_onehot_low(32'(idx_d), NUM_DIGITS);
            seg_d   = src[idx_d];
            an_d    = an_full[NUM_DIGITS-1:0];
        end
    end

    assign an_unused = ^an_full[MAX_DIGITS-1:NUM_DIGITS];

    // Front copies the pre-write back contents, so a same-edge write stays in back.
    always_comb begin
        back_d        = back_q;
        front_d       = front_q;
        wr_err_d      = xfer && !in_range;
        commit_pend_d = commit || (commit_pend_q && !swap);
        if (xfer && in_range) begin
            back_d[w_idx] = w_seg;
        end
        if (swap) begin
            front_d = back_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_q       <= '0;
            back_q        <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            active_q      <= 1'b0;
            commit_pend_q <= 1'b0;
            frame_start_q <= 1'b0;
            wr_err_q      <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
        end else begin
            front_q       <= front_d;
            back_q        <= back_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            commit_pend_q <= commit_pend_d;
            frame_start_q <= frame_start_d;
            wr_err_q      <= wr_err_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign commit_pend = commit_pend_q;
    assign frame_start = frame_start_q;
    assign wr_err      = wr_err_q;
    assign seg         = seg_q;
    assign an          = an_q;

endmodule
